// File: rtl/uart_deframe_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_deframe_if
// Description : Frame handshake and decoded-field bundle between the UART RX
//               shifter (master) and the deframer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_deframe_if;
    // Shifter -> deframer
    logic        recieved_flag;
    logic [10:0] data_parll;

    // Deframer -> byte consumer
    logic        start_bit;
    logic [7:0]  raw_data;
    logic        parity_bit;
    logic        stop_bit;
    logic        done_flag;
    logic        parity_err;
    logic        frame_err;

    modport master (
        output recieved_flag,
        output data_parll,
        input  start_bit,
        input  raw_data,
        input  parity_bit,
        input  stop_bit,
        input  done_flag,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  recieved_flag,
        input  data_parll,
        output start_bit,
        output raw_data,
        output parity_bit,
        output stop_bit,
        output done_flag,
        output parity_err,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_deframe.sv
`default_nettype none
// ============================================================================
// Module      : uart_deframe
// Description : Splits an already-parallelised 11-bit UART frame into start,
//               data, parity and stop fields, checks parity and framing, and
//               flags each newly captured byte with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_deframe #(
    parameter logic PARITY_ODD = 1'b0   // 0 = even parity, 1 = odd parity
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    uart_deframe_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_capture;
    logic        w_done;

    logic        w_parity_err;
    logic        w_frame_err;

    logic        r_start_bit;
    logic [7:0]  r_raw_data;
    logic        r_parity_bit;
    logic        r_stop_bit;
    logic        r_parity_err;
    logic        r_frame_err;

    // Nine-bit XOR is 0 for an even count of ones; flip it for odd parity so
    // a 1 always means the check failed.
    assign w_parity_err = (^bus.data_parll[9:1]) ^ PARITY_ODD;
    // A good frame starts low and stops high.
    assign w_frame_err  = bus.data_parll[0] | ~bus.data_parll[10];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: capture once on entry, then wait for the flag to drop
    // so a flag held high for many cycles yields only one byte.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.recieved_flag) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = bus.recieved_flag ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!bus.recieved_flag) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Field and error capture; values hold until the next capture. Reset
    // values present an idle (high) line with no errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_bit  <= 1'b1;
            r_raw_data   <= 8'h00;
            r_parity_bit <= 1'b0;
            r_stop_bit   <= 1'b1;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (w_capture) begin
            r_start_bit  <= bus.data_parll[0];
            r_raw_data   <= bus.data_parll[8:1];
            r_parity_bit <= bus.data_parll[9];
            r_stop_bit   <= bus.data_parll[10];
            r_parity_err <= w_parity_err;
            r_frame_err  <= w_frame_err;
        end
    end

    // done_flag is decoded straight from the state register, so it drops
    // together with the asynchronous state reset.
    assign bus.done_flag  = w_done;
    assign bus.start_bit  = r_start_bit;
    assign bus.raw_data   = r_raw_data;
    assign bus.parity_bit = r_parity_bit;
    assign bus.stop_bit   = r_stop_bit;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_deframe.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_deframe
// Description : Self-checking bench for uart_deframe (even and odd parity
//               instances driven from the same frame stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_deframe;

    localparam logic [10:0] F_AB = 11'b11101010110; // data AB, good even frame
    localparam logic [10:0] F_7E = 11'b11011111100; // data 7E, bad even parity
    localparam logic [10:0] F_FE = 11'b01011111101; // data 7E, start=1 stop=0

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flag = 1'b0;
    logic [10:0] data = 11'h7FF;

    int total = 0;
    int bad = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    uart_deframe_if u_if_even ();
    uart_deframe_if u_if_odd ();

    assign u_if_even.recieved_flag = flag;
    assign u_if_even.data_parll    = data;
    assign u_if_odd.recieved_flag  = flag;
    assign u_if_odd.data_parll     = data;

    uart_deframe #(.PARITY_ODD(1'b0)) u_dut_even (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if_even)
    );

    uart_deframe #(.PARITY_ODD(1'b1)) u_dut_odd (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if_odd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rule: a byte is taken on any edge where the flag is high, provided the
    // flag has been seen low since the previous capture (or since reset).
    logic [7:0] m_raw    = 8'h00;
    logic       m_start  = 1'b1;
    logic       m_par    = 1'b0;
    logic       m_stop   = 1'b1;
    logic       m_done   = 1'b0;
    logic       m_perr_e = 1'b0;
    logic       m_perr_o = 1'b0;
    logic       m_ferr   = 1'b0;
    logic       m_seen_low = 1'b1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_raw <= 8'h00; m_start <= 1'b1; m_par <= 1'b0; m_stop <= 1'b1;
            m_done <= 1'b0; m_perr_e <= 1'b0; m_perr_o <= 1'b0; m_ferr <= 1'b0;
            m_seen_low <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (flag && m_seen_low) begin
                m_start    <= data[0];
                m_raw      <= data[8:1];
                m_par      <= data[9];
                m_stop     <= data[10];
                // Total ones in data+parity: even wanted for even parity, odd for odd.
                m_perr_e   <= ($countones(data[9:1]) % 2) != 0;
                m_perr_o   <= ($countones(data[9:1]) % 2) == 0;
                m_ferr     <= (data[0] != 1'b0) || (data[10] != 1'b1);
                m_done     <= 1'b1;
                m_seen_low <= 1'b0;
            end else if (!flag) begin
                m_seen_low <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs of both instances against the model.
    always @(negedge clk) begin
        chk("outs_even",
            {u_if_even.start_bit, u_if_even.raw_data, u_if_even.parity_bit, u_if_even.stop_bit,
             u_if_even.done_flag, u_if_even.parity_err, u_if_even.frame_err},
            {m_start, m_raw, m_par, m_stop, m_done, m_perr_e, m_ferr});
        chk("outs_odd",
            {u_if_odd.start_bit, u_if_odd.raw_data, u_if_odd.parity_bit, u_if_odd.stop_bit,
             u_if_odd.done_flag, u_if_odd.parity_err, u_if_odd.frame_err},
            {m_start, m_raw, m_par, m_stop, m_done, m_perr_o, m_ferr});
        if (u_if_even.done_flag) n_pulses++;
    end

    // Hold flag high for n sampled edges, then one low edge.
    task automatic send(input logic [10:0] f, input int n);
        @(negedge clk);
        data = f;
        flag = 1'b1;
        repeat (n) @(negedge clk);
        flag = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset with an all-ones frame on the inputs
        repeat (2) @(negedge clk);
        #1;
        chk("rst_raw",   u_if_even.raw_data,   8'h00);
        chk("rst_start", u_if_even.start_bit,  1'b1);
        chk("rst_stop",  u_if_even.stop_bit,   1'b1);
        chk("rst_par",   u_if_even.parity_bit, 1'b0);
        chk("rst_done",  u_if_even.done_flag,  1'b0);
        chk("rst_errs",  {u_if_even.parity_err, u_if_even.frame_err}, 2'b00);
        reset_n = 1'b1;

        // Valid frame
        send(F_AB, 1);
        chk("ab_raw",    u_if_even.raw_data, 8'hAB);
        chk("ab_fields", {u_if_even.start_bit, u_if_even.parity_bit, u_if_even.stop_bit}, 3'b011);
        chk("ab_errs",   {u_if_even.parity_err, u_if_even.frame_err}, 2'b00);
        chk("ab_pulses", n_pulses, 1);

        // Parity error (even), clean under odd parity
        send(F_7E, 1);
        chk("pe_raw",    u_if_even.raw_data, 8'h7E);
        chk("pe_par",    u_if_even.parity_bit, 1'b1);
        chk("pe_even",   {u_if_even.parity_err, u_if_even.frame_err}, 2'b10);
        chk("pe_odd",    u_if_odd.parity_err, 1'b0);
        chk("pe_pulses", n_pulses, 2);

        // Framing error
        send(F_FE, 1);
        chk("fe_ferr",   u_if_even.frame_err, 1'b1);
        chk("fe_raw",    u_if_even.raw_data, 8'h7E);
        chk("fe_pulses", n_pulses, 3);

        // Flag held 5 edges, frame changes on the third
        @(negedge clk);
        data = F_AB;
        flag = 1'b1;
        repeat (2) @(negedge clk);
        data = F_7E;
        repeat (3) @(negedge clk);
        flag = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_raw",    u_if_even.raw_data, 8'hAB);
        chk("hold_perr",   u_if_even.parity_err, 1'b0);
        chk("hold_pulses", n_pulses, 4);
        send(F_7E, 1);
        chk("rearm_raw",    u_if_even.raw_data, 8'h7E);
        chk("rearm_pulses", n_pulses, 5);

        // Asynchronous reset while in DONE
        @(negedge clk);
        data = F_AB;
        flag = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_done_pre", u_if_even.done_flag, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_done", u_if_even.done_flag, 1'b0);
        chk("mid_outs", {u_if_even.start_bit, u_if_even.raw_data, u_if_even.parity_bit,
                         u_if_even.stop_bit, u_if_even.parity_err, u_if_even.frame_err},
                        {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        flag = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        data = F_7E;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_raw",    u_if_even.raw_data, 8'h00);
        chk("idle_pulses", n_pulses, 5);

        // Flag already high when reset releases
        @(negedge clk);
        reset_n = 1'b0;
        data = F_AB;
        flag = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_raw",    u_if_even.raw_data, 8'hAB);
        chk("rel_pulses", n_pulses, 6);
        flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
